alu_mc: RTL

Parametrised multi-cycle integer ALU for the RISC-V datapath, replacing the single-cycle combinational ALU. It covers all RV32I ALU ops plus RV32M-style MUL/MULHU/DIVU/REMU, which are executed iteratively. Operands enter and results leave through valid/ready handshakes so the execute stage can stall on long ops. It sits between the register-read and writeback stages.

---
 rtl/alu_mc.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle integer ALU with valid/ready handshakes
// Single-cycle RV32I ops plus iterative MUL/MULHU/DIVU/REMU sharing one accumulator.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero_flag,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_next;
  logic [CW-1:0]        cnt;
  logic [3:0]           op_q;
  logic [WIDTH-1:0]     opnd;
  logic [2*WIDTH-1:0]   acc, acc_step;
  logic [WIDTH-1:0]     quick_res, iter_res, div_diff;
  logic [WIDTH:0]       mul_sum, rem_sh;
  logic [SW-1:0]        shamt;
  logic                 accept, last_step, is_iter, is_mul, q_is_mul;

  assign shamt    = b[SW-1:0];
  assign is_iter  = (opcode >= 4'd10) && (opcode <= 4'd13);
  assign is_mul   = (opcode[3:1] == 3'b101);
  assign q_is_mul = (op_q[3:1] == 3'b101);

  always_comb begin
    quick_res = '0;
    case (opcode)
      OP_ADD:  quick_res = a + b;
      OP_SUB:  quick_res = a - b;
      OP_AND:  quick_res = a & b;
      OP_OR:   quick_res = a | b;
      OP_XOR:  quick_res = a ^ b;
      OP_SLL:  quick_res = a << shamt;
      OP_SRL:  quick_res = a >> shamt;
      OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SRA:  quick_res = $unsigned($signed(a) >>> shamt);
      OP_SLTU: quick_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: quick_res = '0;
    endcase
  end

  // Multiply: acc = {partial high, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){acc[0]}} & {1'b0, opnd});
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = rem_sh[WIDTH-1:0] - opnd;
    if (q_is_mul)
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (rem_sh >= {1'b0, opnd})
      acc_step = {div_diff, acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    iter_res = op_q[0] ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        accept   = in_valid && !rst && !flush;
        if (accept) state_next = is_iter ? BUSY : DONE;
      end
      BUSY: begin
        busy      = 1'b1;
        last_step = (cnt == CW'(1));
        if (last_step) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res       <= '0;
      zero_flag <= 1'b1;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      op_q      <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      op_q <= opcode;
      if (is_iter) begin
        cnt  <= CW'(WIDTH);
        opnd <= is_mul ? a : b;
        acc  <= {{WIDTH{1'b0}}, (is_mul ? b : a)};
      end else begin
        res       <= quick_res;
        zero_flag <= (quick_res == '0);
      end
    end else if (busy) begin
      acc <= acc_step;
      cnt <= cnt - CW'(1);
      if (last_step) begin
        res       <= iter_res;
        zero_flag <= (iter_res == '0);
      end
    end
  end

endmodule
